leaf_stream_packetizer: RTL and testbench
=========================================

// Module: leaf_stream_packetizer
// PURPOSE
//  Transmit end of a leaf input port. Packs a 32-bit vld/ack word stream into 49-bit BFT packets
//  addressed to one (leaf, port) of a remote leaf_interface. Gated by the receiver's freespace
//  credits so the receive BRAM never overflows. Sits on the 400 MHz BFT side of a DMA/host leaf.
// PARAMETERS
//  PACKET_BITS           49   packet width: {vld[48], leaf[47:43], port[42:39], addr[38:32], payload[31:0]}
//  PAYLOAD_BITS          32   payload width
//  NUM_LEAF_BITS         5    leaf field width
//  NUM_PORT_BITS         4    port field width
//  NUM_ADDR_BITS         7    addr field width
//  NUM_BRAM_ADDR_BITS    7    receiver buffer depth = 2**7 = 128 words = initial credit
//  SELF_LEAF             1    this leaf's number; credit updates arrive addressed to it
// PORTS
//  clk                      in   1    single clock (400 MHz BFT domain)
//  reset                    in   1    synchronous, active-high
//  dest_leaf                in   5    target leaf; sampled on ap_start
//  dest_port                in   4    target input port, 2..15 (0/1 reserved); sampled on ap_start
//  ap_start                 in   1    one-cycle pulse: leave IDLE, start streaming
//  din_user2packetizer      in   32   stream payload
//  vld_user2packetizer      in   1    stream valid
//  ack_packetizer2user      out  1    stream ack; word transfers when vld & ack
//  din_leaf_bft2interface   in   49   packets from BFT (credit updates only)
//  dout_leaf_interface2bft  out  49   packets to BFT; bit 48 = valid
//  bft_ready                in   1    BFT accepts the held output packet this cycle
//  resend                   in   1    freeze: output forced 0, no transfers
//  credit_cnt               out  8    current credit, 0..128
//  credit_err               out  1    sticky: credit update would exceed 128
// BEHAVIOUR
//  Reset values: ack=0, dout=0, credit_cnt=128, credit_err=0, addr pointer=0, state=IDLE.
//  States:
//   - IDLE: ack=0. ap_start latches dest_leaf and dest_port, then goes to SEND.
//   - SEND: ack = (credit_cnt!=0) & ~resend & (~out_vld | bft_ready). Goes to STALL when credit_cnt
//     reaches 0 and no update is arriving.
//   - STALL: ack=0. Returns to SEND on the first cycle credit_cnt becomes nonzero.
//   - ap_start while not IDLE is ignored.
//  Output register:
//   - On transfer, the next cycle presents {1, dest_leaf, dest_port, addr, data}; latency 1.
//   - The packet holds until bft_ready. The register clears when bft_ready is high and no new
//     transfer occurs. Back-to-back transfers give one packet per cycle.
//  Address: 7-bit pointer, +1 per transfer, wraps 127->0.
//  Credit update:
//   - Recognised when din[48]=1, din[47:43]=SELF_LEAF and din[42:39]=0.
//   - Increment = din[7:0]; in practice 64 (FREESPACE_UPDATE_SIZE).
//   - Other packets are ignored.
//  Credit arithmetic, same cycle:
//   - credit_next = credit - xfer + incr.
//   - If the result exceeds 128: clamp to 128 and set credit_err.
//   - A simultaneous transfer and update both apply.
//  resend:
//   - dout is combinationally forced to 0 and ack=0.
//   - Output register, pointer and credit are held.
//   - Normal output resumes the cycle after resend falls.
//  Reset mid-packet: the held packet is dropped and the receiver must also be reset; no replay.
// STRUCTURE
//  Shared package (bft_pkg):
//   - Field offsets/widths for vld/leaf/port/addr/payload.
//   - CTRL_PORT=0 (credit updates); state enum {IDLE,SEND,STALL}.
//  One sub-module, leaf_credit_counter:
//   - Credit register, decrement/increment/saturate, credit_err.
//   - The top holds FSM, pointer, output register, update decoder.
// TESTING
//  1) Reset, ap_start with dest 3/2, 4 words 0xA0..0xA3 ->
//     packets 0x1_3_2_00_A0..0x1_3_2_03_A3 (hex fields), one per cycle; credit_cnt=124.
//  2) Stream 128 words with no updates -> ack drops after word 128; state STALL; no 129th packet.
//  3) In STALL, inject update {1,SELF_LEAF,0,0,64} -> ack returns next cycle; 64 more words send
//     at addr 0..63 (wrapped).
//  4) Update arriving in the same cycle as a transfer at credit=1 -> credit_cnt=64; no stall cycle.
//  5) bft_ready low 3 cycles mid-stream -> packet held stable, ack=0, no loss or duplication.
//     resend pulse -> dout=0 during pulse, same packet after.
//  6) Update of 64 at credit=100 -> credit_cnt=128 and credit_err=1, sticky until reset.

Source files
------------

// File: rtl/leaf_stream_packetizer_pkg.sv
// Shared definitions for the leaf stream packetizer: BFT packet field layout,
// credit sizing, FSM state encoding and packet build/decode helpers.
package leaf_stream_packetizer_pkg;

  localparam int PACKET_BITS        = 49;
  localparam int PAYLOAD_BITS       = 32;
  localparam int NUM_LEAF_BITS      = 5;
  localparam int NUM_PORT_BITS      = 4;
  localparam int NUM_ADDR_BITS      = 7;
  localparam int NUM_BRAM_ADDR_BITS = 7;

  // Field positions inside a packet: {vld, leaf, port, addr, payload}
  localparam int VLD_BIT     = PACKET_BITS - 1;
  localparam int LEAF_LSB    = VLD_BIT - NUM_LEAF_BITS;
  localparam int PORT_LSB    = LEAF_LSB - NUM_PORT_BITS;
  localparam int ADDR_LSB    = PORT_LSB - NUM_ADDR_BITS;
  localparam int PAYLOAD_LSB = 0;

  // Credit counts 0..2**NUM_BRAM_ADDR_BITS inclusive, hence one extra bit
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(2 ** NUM_BRAM_ADDR_BITS);

  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

  typedef logic [PACKET_BITS-1:0] packet_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  function automatic packet_t make_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, addr, payload};
  endfunction

  function automatic logic is_credit_update(
    input packet_t                  p,
    input logic [NUM_LEAF_BITS-1:0] self_leaf
  );
    return p[VLD_BIT] &&
           (p[LEAF_LSB +: NUM_LEAF_BITS] == self_leaf) &&
           (p[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);
  endfunction

  function automatic logic [CREDIT_BITS-1:0] credit_incr(input packet_t p);
    return p[PAYLOAD_LSB +: CREDIT_BITS];
  endfunction

endpackage

// File: rtl/leaf_stream_packetizer_if.sv
// Stream and BFT signals of the packetizer. The user side (master) drives the
// word stream and BFT inputs; the packetizer (slave) drives ack and the packet.
interface leaf_stream_packetizer_if;
  import leaf_stream_packetizer_pkg::*;

  // Handshakes: a stream word moves on a cycle with vld_user2packetizer &
  // ack_packetizer2user; ack never waits on vld. A packet with bit 48 set on
  // dout_leaf_interface2bft is consumed on a cycle with bft_ready high and is
  // held unchanged until then. resend high blocks both handshakes.
  logic [PAYLOAD_BITS-1:0] din_user2packetizer;
  logic                    vld_user2packetizer;
  logic                    ack_packetizer2user;
  packet_t                 din_leaf_bft2interface;
  packet_t                 dout_leaf_interface2bft;
  logic                    bft_ready;
  logic                    resend;

  modport master (
    output din_user2packetizer,
    output vld_user2packetizer,
    input  ack_packetizer2user,
    output din_leaf_bft2interface,
    input  dout_leaf_interface2bft,
    output bft_ready,
    output resend
  );

  modport slave (
    input  din_user2packetizer,
    input  vld_user2packetizer,
    output ack_packetizer2user,
    input  din_leaf_bft2interface,
    output dout_leaf_interface2bft,
    input  bft_ready,
    input  resend
  );

endinterface

// File: rtl/leaf_stream_packetizer_credit_counter.sv
// Receiver freespace credit: one credit spent per word sent, refilled by
// credit updates, saturating at the receive buffer depth with a sticky error.
module leaf_credit_counter
  import leaf_stream_packetizer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   xfer,
  input  logic                   upd_vld,
  input  logic [CREDIT_BITS-1:0] upd_incr,
  output logic [CREDIT_BITS-1:0] credit_cnt,
  output logic [CREDIT_BITS-1:0] credit_next,
  output logic                   credit_err
);

  localparam int SUM_BITS = CREDIT_BITS + 2;

  logic [SUM_BITS-1:0] sum;
  logic                over;

  // Spend and refill land in the same cycle; the wide sum keeps overflow visible
  always_comb begin
    sum = SUM_BITS'(credit_cnt) - SUM_BITS'(xfer);
    if (upd_vld) begin
      sum = sum + SUM_BITS'(upd_incr);
    end
    over        = (sum > SUM_BITS'(CREDIT_MAX));
    credit_next = over ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      credit_cnt <= credit_next;
      if (over) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Transmit end of a leaf input port: packs a vld/ack word stream into BFT
// packets for one remote (leaf, port), throttled by receiver credits.
module leaf_stream_packetizer
  import leaf_stream_packetizer_pkg::*;
#(
  parameter logic [NUM_LEAF_BITS-1:0] SELF_LEAF = NUM_LEAF_BITS'(1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic                     ap_start,
  leaf_stream_packetizer_if.slave  bus,
  output logic [CREDIT_BITS-1:0]   credit_cnt,
  output logic                     credit_err,
  output state_t                   state_dbg
);

  state_t                   state;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  packet_t                  out_q;

  logic                     out_vld;
  logic                     ack;
  logic                     xfer;
  logic                     upd_vld;
  logic [CREDIT_BITS-1:0]   upd_incr;
  logic [CREDIT_BITS-1:0]   credit_next;

  assign out_vld = out_q[VLD_BIT];

  // A new word may enter only when the output slot is empty or draining now
  assign ack  = (state == SEND) && (credit_cnt != '0) && !bus.resend &&
                (!out_vld || bus.bft_ready);
  assign xfer = ack && bus.vld_user2packetizer;

  // Credit updates are dropped while frozen so all state holds still
  assign upd_vld  = !bus.resend && is_credit_update(bus.din_leaf_bft2interface, SELF_LEAF);
  assign upd_incr = credit_incr(bus.din_leaf_bft2interface);

  assign bus.ack_packetizer2user     = ack;
  assign bus.dout_leaf_interface2bft = bus.resend ? '0 : out_q;
  assign state_dbg                   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      leaf_q <= '0;
      port_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            leaf_q <= dest_leaf;
            port_q <= dest_port;
            state  <= SEND;
          end
        end
        SEND: begin
          if (credit_next == '0) begin
            state <= STALL;
          end
        end
        STALL: begin
          if (credit_next != '0) begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      out_q  <= '0;
    end else if (!bus.resend) begin
      if (xfer) begin
        out_q  <= make_packet(leaf_q, port_q, addr_q, bus.din_user2packetizer);
        addr_q <= addr_q + NUM_ADDR_BITS'(1);
      end else if (bus.bft_ready) begin
        out_q <= '0;
      end
    end
  end

  leaf_credit_counter u_credit (
    .clk         (clk),
    .reset       (reset),
    .xfer        (xfer),
    .upd_vld     (upd_vld),
    .upd_incr    (upd_incr),
    .credit_cnt  (credit_cnt),
    .credit_next (credit_next),
    .credit_err  (credit_err)
  );

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed bench for leaf_stream_packetizer: packets are predicted into a queue
// when a word is accepted and checked when the BFT consumes them.
module tb_leaf_stream_packetizer;
  import leaf_stream_packetizer_pkg::*;

  localparam int XFER_LIMIT = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] dest_leaf;
  logic [3:0] dest_port;
  logic       ap_start;
  logic [7:0] credit_cnt;
  logic       credit_err;
  state_t     state_dbg;

  leaf_stream_packetizer_if bus();

  leaf_stream_packetizer #(.SELF_LEAF(5'd1)) dut (
    .clk        (clk),
    .reset      (reset),
    .dest_leaf  (dest_leaf),
    .dest_port  (dest_port),
    .ap_start   (ap_start),
    .bus        (bus),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_q[$];
  logic [6:0]  exp_addr;
  logic [4:0]  mdl_leaf;
  logic [3:0]  mdl_port;
  logic        last_xfer;
  logic [48:0] held;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [48:0] mk_pkt(input logic [4:0] l, input logic [3:0] p,
                                         input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  function automatic logic [48:0] mk_upd(input logic [4:0] l, input logic [7:0] incr);
    return {1'b1, l, 4'd0, 7'd0, 24'd0, incr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs once per cycle at the falling edge, inputs stable
  task automatic sb_step();
    logic [48:0] e;
    if (reset) begin
      exp_q.delete();
      exp_addr  = '0;
      last_xfer = 1'b0;
    end else begin
      if (bus.dout_leaf_interface2bft[48] && bus.bft_ready) begin
        check("pkt_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pkt", 64'(bus.dout_leaf_interface2bft), 64'(e));
        end
      end
      last_xfer = bus.vld_user2packetizer && bus.ack_packetizer2user;
      if (last_xfer) begin
        exp_q.push_back(mk_pkt(mdl_leaf, mdl_port, exp_addr, bus.din_user2packetizer));
        exp_addr = exp_addr + 7'd1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sb_edge();
    @(negedge clk);
    sb_step();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sb_edge();
    next();
  endtask

  // Leaves vld high afterwards so consecutive calls stream back-to-back
  task automatic send_word(input logic [31:0] d);
    int waited = 0;
    bus.vld_user2packetizer = 1'b1;
    bus.din_user2packetizer = d;
    forever begin
      sb_edge();
      next();
      if (last_xfer) break;
      waited++;
      if (waited >= XFER_LIMIT) begin
        check("xfer_timeout", 64'(last_xfer), 64'd1);
        break;
      end
    end
  endtask

  task automatic start(input logic [4:0] l, input logic [3:0] p);
    dest_leaf = l;
    dest_port = p;
    ap_start  = 1'b1;
    mdl_leaf  = l;
    mdl_port  = p;
    step();
    ap_start  = 1'b0;
    dest_leaf = ~l;
    dest_port = ~p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    dest_leaf = '0;
    dest_port = '0;
    ap_start  = 1'b0;
    mdl_leaf  = '0;
    mdl_port  = '0;
    held      = '0;
    bus.din_user2packetizer    = '0;
    bus.vld_user2packetizer    = 1'b0;
    bus.din_leaf_bft2interface = '0;
    bus.bft_ready              = 1'b1;
    bus.resend                 = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    sb_edge();
    check("rst_ack", 64'(bus.ack_packetizer2user), 64'd0);
    check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    check("rst_credit", 64'(credit_cnt), 64'd128);
    check("rst_err", 64'(credit_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    next();

    // 1) four words to leaf 3 port 2
    start(5'd3, 4'd2);
    for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i));
    bus.vld_user2packetizer = 1'b0;
    step();
    sb_edge();
    check("t1_credit", 64'(credit_cnt), 64'd124);
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    next();

    // 2) exhaust all 128 credits
    do_reset();
    start(5'd7, 4'd5);
    for (int i = 0; i < 128; i++) send_word($urandom());
    bus.din_user2packetizer = 32'hDEAD_BEEF;
    sb_edge();
    check("t2_ack_low", 64'(bus.ack_packetizer2user), 64'd0);
    check("t2_state", 64'(state_dbg), 64'(STALL));
    check("t2_credit", 64'(credit_cnt), 64'd0);
    next();
    step();
    sb_edge();
    check("t2_no_extra_pkt", 64'(bus.dout_leaf_interface2bft), 64'd0);
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    next();
    bus.vld_user2packetizer = 1'b0;

    // 3) update for another leaf is ignored, then a real refill
    bus.din_leaf_bft2interface = mk_upd(5'd2, 8'd64);
    step();
    bus.din_leaf_bft2interface = '0;
    sb_edge();
    check("t3_ignored_upd", 64'(credit_cnt), 64'd0);
    next();
    bus.din_leaf_bft2interface = mk_upd(5'd1, 8'd64);
    sb_edge();
    check("t3_ack_upd_cycle", 64'(bus.ack_packetizer2user), 64'd0);
    next();
    bus.din_leaf_bft2interface = '0;
    sb_edge();
    check("t3_ack_back", 64'(bus.ack_packetizer2user), 64'd1);
    check("t3_state", 64'(state_dbg), 64'(SEND));
    check("t3_credit", 64'(credit_cnt), 64'd64);
    next();
    for (int i = 0; i < 64; i++) send_word(32'h3000 + 32'(i));
    sb_edge();
    check("t3_stall_again", 64'(state_dbg), 64'(STALL));
    next();
    bus.vld_user2packetizer = 1'b0;

    // 4) update coinciding with the last-credit transfer
    bus.din_leaf_bft2interface = mk_upd(5'd1, 8'd1);
    step();
    bus.din_leaf_bft2interface = '0;
    sb_edge();
    check("t4_credit_one", 64'(credit_cnt), 64'd1);
    next();
    bus.vld_user2packetizer    = 1'b1;
    bus.din_user2packetizer    = 32'h4444_0001;
    bus.din_leaf_bft2interface = mk_upd(5'd1, 8'd64);
    sb_edge();
    check("t4_xfer", 64'(last_xfer), 64'd1);
    next();
    bus.din_leaf_bft2interface = '0;
    bus.vld_user2packetizer    = 1'b0;
    sb_edge();
    check("t4_credit", 64'(credit_cnt), 64'd64);
    check("t4_no_stall", 64'(state_dbg), 64'(SEND));
    next();

    // 5) backpressure holds the packet, resend blanks it
    send_word(32'h5000_0000);
    held = exp_q[0];
    bus.bft_ready = 1'b0;
    bus.din_user2packetizer = 32'h5000_0001;
    for (int i = 0; i < 3; i++) begin
      sb_edge();
      check("t5_hold_ack", 64'(bus.ack_packetizer2user), 64'd0);
      check("t5_hold_pkt", 64'(bus.dout_leaf_interface2bft), 64'(held));
      next();
    end
    bus.bft_ready = 1'b1;
    send_word(32'h5000_0001);
    held = exp_q[0];
    bus.resend = 1'b1;
    bus.din_user2packetizer = 32'h5000_0002;
    for (int i = 0; i < 2; i++) begin
      sb_edge();
      check("t5_resend_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
      check("t5_resend_ack", 64'(bus.ack_packetizer2user), 64'd0);
      next();
    end
    bus.resend = 1'b0;
    sb_edge();
    check("t5_resume_pkt", 64'(bus.dout_leaf_interface2bft), 64'(held));
    check("t5_resume_xfer", 64'(last_xfer), 64'd1);
    next();
    bus.vld_user2packetizer = 1'b0;
    step();
    sb_edge();
    check("t5_drained", 64'(exp_q.size()), 64'd0);
    check("t5_credit", 64'(credit_cnt), 64'd61);
    next();

    // 6) refill past the buffer depth saturates and latches the error
    do_reset();
    start(5'd9, 4'd4);
    for (int i = 0; i < 28; i++) send_word(32'(i) * 32'h0101_0101);
    bus.vld_user2packetizer = 1'b0;
    sb_edge();
    check("t6_credit_100", 64'(credit_cnt), 64'd100);
    next();
    bus.din_leaf_bft2interface = mk_upd(5'd1, 8'd64);
    step();
    bus.din_leaf_bft2interface = '0;
    sb_edge();
    check("t6_clamp", 64'(credit_cnt), 64'd128);
    check("t6_err", 64'(credit_err), 64'd1);
    next();
    send_word(32'h6666_6666);
    bus.vld_user2packetizer = 1'b0;
    step();
    sb_edge();
    check("t6_err_sticky", 64'(credit_err), 64'd1);
    check("t6_credit_127", 64'(credit_cnt), 64'd127);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    next();
    do_reset();
    sb_edge();
    check("t6_err_cleared", 64'(credit_err), 64'd0);
    check("t6_rst_credit", 64'(credit_cnt), 64'd128);
    check("t6_rst_state", 64'(state_dbg), 64'(IDLE));
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
